// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: opcode fields used by the decoders,
// the canonical NOP encoding and the fetch-stage state encoding.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// XLEN-wide program-counter register with load enable and
// asynchronous active-high reset to RESET_PC.
module pc_reg #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= RESET_PC;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding instruction-memory read, an instruction
// register presented to decode with valid/ready, and redirect squashing.
//
// Handshakes:
//   imem: a request transfers in a cycle where imem_req && imem_gnt; exactly
//         one imem_rvalid answers it, possibly several cycles later.
//   decode: Instr/PC transfer in a cycle where InstrValid && DecReady; while
//         InstrValid is high without DecReady, Instr and PC do not change.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            DecReady,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   output logic [31:0]     Instr,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic            InstrValid,
   output logic [1:0]      state_dbg
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
   localparam logic [XLEN-1:0] FOUR       = {{(XLEN-3){1'b0}}, 3'b100};

   fetch_state_t    state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] pc_inflight;
   logic            drop;

   logic [XLEN-1:0] target_aligned;
   logic            accept;
   logic            fpc_en;
   logic [XLEN-1:0] fpc_d;

   assign target_aligned = PCTarget & ALIGN_MASK;

   // A returned word is kept only if no redirect has overtaken it.
   assign accept = (state == WAIT) && imem_rvalid && !drop && !PCSrc;

   // A redirect overwrites the fetch address in every state.
   always_comb begin
      fpc_en = 1'b0;
      fpc_d  = fetch_pc;
      if (PCSrc) begin
         fpc_en = 1'b1;
         fpc_d  = target_aligned;
      end else if (accept) begin
         fpc_en = 1'b1;
         fpc_d  = pc_inflight + FOUR;
      end
   end

   pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_fetch_pc (
      .clk   (clk),
      .reset (reset),
      .en    (fpc_en),
      .d     (fpc_d),
      .q     (fetch_pc)
   );

   pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .d     (pc_inflight),
      .q     (PC)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         Instr       <= NOP_INSTR;
         InstrValid  <= 1'b0;
         drop        <= 1'b0;
         pc_inflight <= RESET_PC;
      end else begin
         case (state)
            FETCH: begin
               if (!PCSrc && imem_gnt) begin
                  pc_inflight <= fetch_pc;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (drop || PCSrc) begin
                     drop  <= 1'b0;
                     state <= FETCH;
                  end else begin
                     Instr      <= imem_rdata;
                     InstrValid <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (PCSrc) begin
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (PCSrc || DecReady) begin
                  InstrValid <= 1'b0;
                  state      <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign imem_req  = (state == FETCH) && !PCSrc && !reset;
   assign imem_addr = fetch_pc;
   assign PCPlus4   = PC + FOUR;
   assign state_dbg = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table covering the
// normal flow, stalls, redirects and wrap, then a reset-in-WAIT sequence.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        DecReady;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        InstrValid;
   logic [1:0]  state_dbg;

   int passed = 0;
   int total  = 0;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .DecReady    (DecReady),
      .PCSrc       (PCSrc),
      .PCTarget    (PCTarget),
      .Instr       (Instr),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .InstrValid  (InstrValid),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        dr;
      logic        src;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  st;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic gnt, input logic rv, input logic [31:0] rdata,
                      input logic dr, input logic src, input logic [31:0] tgt,
                      input logic req, input logic [31:0] addr, input logic v,
                      input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] st);
      vec_t e;
      e.gnt = gnt; e.rv = rv; e.rdata = rdata; e.dr = dr; e.src = src; e.tgt = tgt;
      e.req = req; e.addr = addr; e.v = v; e.instr = instr; e.pc = pc; e.st = st;
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s[%0d]: got %08h, expected %08h", name, idx, act, exp);
   endtask

   task automatic set_in(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic dr, input logic src, input logic [31:0] tgt);
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rdata;
      DecReady    = dr;
      PCSrc       = src;
      PCTarget    = tgt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      //   gnt rv rdata         dr src tgt            req addr          v  instr         pc            st
      add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h13,       32'h0,        0); // c0
      add(0, 1, 32'h00500093, 0, 0, 32'h0,         0, 32'h0,        0, 32'h13,       32'h0,        1);
      add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h4,        1, 32'h00500093, 32'h0,        2); // c2
      add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,        0, 32'h00500093, 32'h0,        0);
      add(0, 1, 32'h00A00113, 0, 0, 32'h0,         0, 32'h4,        0, 32'h00500093, 32'h0,        1);
      for (int k = 0; k < 5; k++)
         add(0, 0, 32'h0,     0, 0, 32'h0,         0, 32'h8,        1, 32'h00A00113, 32'h4,        2); // stall
      add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h8,        1, 32'h00A00113, 32'h4,        2); // c10
      add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h8,        0, 32'h00A00113, 32'h4,        0);
      add(0, 1, 32'h00000063, 0, 0, 32'h0,         0, 32'h8,        0, 32'h00A00113, 32'h4,        1);
      add(0, 0, 32'h0,        1, 1, 32'h101,       0, 32'hC,        1, 32'h00000063, 32'h8,        2); // redirect in HOLD
      add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h100,      0, 32'h00000063, 32'h8,        0);
      add(0, 0, 32'h0,        0, 1, 32'h40,        0, 32'h100,      0, 32'h00000063, 32'h8,        1); // redirect in WAIT
      add(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h40,       0, 32'h00000063, 32'h8,        1);
      add(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h40,       0, 32'h00000063, 32'h8,        1);
      add(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 32'h40,       0, 32'h00000063, 32'h8,        1); // discarded
      add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h40,       0, 32'h00000063, 32'h8,        0);
      add(0, 1, 32'h0000006F, 0, 0, 32'h0,         0, 32'h40,       0, 32'h00000063, 32'h8,        1);
      add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h44,       1, 32'h0000006F, 32'h40,       2);
      add(0, 0, 32'h0,        0, 1, 32'hFFFFFFFF,  0, 32'h44,       0, 32'h0000006F, 32'h40,       0); // redirect in FETCH
      for (int k = 0; k < 4; k++)
         add(0, 0, 32'h0,     0, 0, 32'h0,         1, 32'hFFFFFFFC, 0, 32'h0000006F, 32'h40,       0); // gnt withheld
      add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFFFFFC, 0, 32'h0000006F, 32'h40,       0);
      add(0, 1, 32'h00000013, 0, 0, 32'h0,         0, 32'hFFFFFFFC, 0, 32'h0000006F, 32'h40,       1);
      add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        1, 32'h00000013, 32'hFFFFFFFC, 2); // wrap
      add(0, 1, 32'h00000BAD, 0, 0, 32'h0,         1, 32'h0,        0, 32'h00000013, 32'hFFFFFFFC, 0); // stray rvalid
      add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h00000013, 32'hFFFFFFFC, 0);

      step();
      step();
      chk("rst_req",   0, {31'h0, imem_req},   32'h0);
      chk("rst_valid", 0, {31'h0, InstrValid}, 32'h0);
      chk("rst_instr", 0, Instr,               32'h0000_0013);
      chk("rst_pc",    0, PC,                  32'h0);
      chk("rst_addr",  0, imem_addr,           32'h0);
      chk("rst_state", 0, {30'h0, state_dbg},  32'h0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         set_in(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].dr, vecs[i].src, vecs[i].tgt);
         @(negedge clk);
         chk("req",     i, {31'h0, imem_req},   {31'h0, vecs[i].req});
         chk("addr",    i, imem_addr,           vecs[i].addr);
         chk("valid",   i, {31'h0, InstrValid}, {31'h0, vecs[i].v});
         chk("instr",   i, Instr,               vecs[i].instr);
         chk("pc",      i, PC,                  vecs[i].pc);
         chk("pcplus4", i, PCPlus4,             vecs[i].pc + 32'd4);
         chk("state",   i, {30'h0, state_dbg},  {30'h0, vecs[i].st});
         step();
      end

      // Reset pulsed while a request is outstanding, late rvalid afterwards.
      set_in(1, 0, 32'h0, 0, 0, 32'h0);        step();
      set_in(0, 1, 32'h00500093, 0, 0, 32'h0); step();
      set_in(0, 0, 32'h0, 1, 0, 32'h0);        step();
      set_in(1, 0, 32'h0, 0, 0, 32'h0);        step();
      set_in(0, 0, 32'h0, 0, 0, 32'h0);
      #1;
      chk("pre_rst_state", 0, {30'h0, state_dbg}, 32'h1);
      chk("pre_rst_instr", 0, Instr,              32'h00500093);
      reset = 1'b1;
      #1;
      chk("mid_rst_state", 0, {30'h0, state_dbg},  32'h0);
      chk("mid_rst_valid", 0, {31'h0, InstrValid}, 32'h0);
      chk("mid_rst_instr", 0, Instr,               32'h0000_0013);
      chk("mid_rst_addr",  0, imem_addr,           32'h0);
      chk("mid_rst_req",   0, {31'h0, imem_req},   32'h0);
      step();
      reset = 1'b0;
      set_in(0, 1, 32'hDEADBEEF, 0, 0, 32'h0);
      @(negedge clk);
      chk("late_rv_req",   0, {31'h0, imem_req},  32'h1);
      chk("late_rv_addr",  0, imem_addr,          32'h0);
      step();
      set_in(0, 0, 32'h0, 0, 0, 32'h0);
      @(negedge clk);
      chk("late_rv_state", 0, {30'h0, state_dbg},  32'h0);
      chk("late_rv_valid", 0, {31'h0, InstrValid}, 32'h0);
      chk("late_rv_instr", 0, Instr,               32'h0000_0013);
      step();
      set_in(1, 0, 32'h0, 0, 0, 32'h0);        step();
      set_in(0, 1, 32'h00100073, 0, 0, 32'h0); step();
      set_in(0, 0, 32'h0, 0, 0, 32'h0);
      @(negedge clk);
      chk("restart_valid", 0, {31'h0, InstrValid}, 32'h1);
      chk("restart_instr", 0, Instr,               32'h00100073);
      chk("restart_pc",    0, PC,                  32'h0);
      chk("restart_addr",  0, imem_addr,           32'h4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
